// File: rtl/pipe_cla_adder_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Default geometry lives here so every user of the adder agrees on it.
package pipe_cla_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;
  localparam int DEF_TAG_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Subtract is A + ~B + 1, so the caller's carry-in only matters for add.
  function automatic logic entry_cin(op_e op, logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/cla_block.sv
// One carry-lookahead group: per-bit propagate/generate, prefix carries,
// group propagate/generate and the carry out of the group.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             gp,
  output logic             gg,
  output logic             cout,
  output logic             c_top
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] c;
  logic             g_acc;
  logic             p_acc;

  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    g_acc = 1'b0;
    p_acc = 1'b1;
    // c[i] uses the group P/G of bits below i, so no carry ripples bit to bit
    for (int i = 0; i < BLOCK; i++) begin
      c[i]  = g_acc | (p_acc & cin);
      g_acc = g[i] | (p[i] & g_acc);
      p_acc = p_acc & p[i];
    end
  end

  assign sum   = p ^ c;
  assign gp    = p_acc;
  assign gg    = g_acc;
  assign cout  = g_acc | (p_acc & cin);
  assign c_top = c[BLOCK-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// Skewed pipelined adder/subtractor: each stage resolves one BLOCK-bit
// lookahead group and hands the registered carry to the next stage.
module pipe_cla_adder
  import pipe_cla_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NBLK = WIDTH / BLOCK;

  function automatic logic [BLOCK-1:0] b_eff(op_e op, logic [BLOCK-1:0] b);
    return (op == OP_SUB) ? ~b : b;
  endfunction

  logic advance;
  logic accept;

  // The whole pipe moves as one; only a held, unconsumed result stops it.
  assign in_ready = !(out_valid && !out_ready);
  assign advance  = in_ready;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < NBLK; k++) begin : stg
    localparam int DONE = (k + 1) * BLOCK;
    localparam int REM  = WIDTH - DONE;
    localparam int UP   = REM + BLOCK;

    logic             up_v;
    logic             up_c;
    op_e              up_op;
    logic [UP-1:0]    up_a;
    logic [UP-1:0]    up_b;
    logic [TAG_W-1:0] up_tag;
    logic [DONE-1:0]  new_sum;

    logic [BLOCK-1:0] blk_b;
    logic [BLOCK-1:0] blk_sum;
    logic             blk_gp;
    logic             blk_gg;
    logic             blk_cout;
    logic             blk_ctop;
    logic             take;

    logic             vld_q,  vld_d;
    logic             cy_q,   cy_d;
    logic [TAG_W-1:0] tag_q,  tag_d;
    logic [DONE-1:0]  sum_q,  sum_d;

    // ---- stage k input: fresh operation or the previous stage register ----
    if (k == 0) begin : src
      assign up_v    = accept;
      assign up_op   = op_e'(in_op);
      assign up_a    = in_a;
      assign up_b    = in_b;
      assign up_c    = entry_cin(op_e'(in_op), in_cin);
      assign up_tag  = in_tag;
      assign new_sum = blk_sum;
    end else begin : src
      assign up_v    = stg[k-1].vld_q;
      assign up_op   = stg[k-1].rem.op_q;
      assign up_a    = stg[k-1].rem.a_q;
      assign up_b    = stg[k-1].rem.b_q;
      assign up_c    = stg[k-1].cy_q;
      assign up_tag  = stg[k-1].tag_q;
      assign new_sum = {blk_sum, stg[k-1].sum_q};
    end

    assign blk_b = b_eff(up_op, up_b[BLOCK-1:0]);
    assign take  = advance && up_v;

    cla_block #(
      .BLOCK (BLOCK)
    ) u_cla (
      .a     (up_a[BLOCK-1:0]),
      .b     (blk_b),
      .cin   (up_c),
      .sum   (blk_sum),
      .gp    (blk_gp),
      .gg    (blk_gg),
      .cout  (blk_cout),
      .c_top (blk_ctop)
    );

    always_comb begin
      vld_d = vld_q;
      cy_d  = cy_q;
      tag_d = tag_q;
      sum_d = sum_q;
      if (advance) vld_d = up_v;
      if (take) begin
        cy_d  = blk_cout;
        tag_d = up_tag;
        sum_d = new_sum;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) vld_q <= 1'b0;
      else       vld_q <= vld_d;
    end

    // Only the output stage's payload is visible, so only it is cleared.
    always_ff @(posedge clock) begin
      if (reset && (k == NBLK - 1)) begin
        cy_q  <= 1'b0;
        tag_q <= '0;
        sum_q <= '0;
      end else begin
        cy_q  <= cy_d;
        tag_q <= tag_d;
        sum_q <= sum_d;
      end
    end

    // ---- stage k register: pending operand bits travel with the op ----
    if (REM > 0) begin : rem
      logic [REM-1:0] a_q, a_d;
      logic [REM-1:0] b_q, b_d;
      op_e            op_q, op_d;
      logic           blk_unused;

      assign blk_unused = ^{blk_gp, blk_gg, blk_ctop};

      always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        if (take) begin
          a_d  = up_a[UP-1:BLOCK];
          b_d  = up_b[UP-1:BLOCK];
          op_d = up_op;
        end
      end

      always_ff @(posedge clock) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
      end
    end else begin : fin
      logic ovf_q,  ovf_d;
      logic zero_q, zero_d;
      logic blk_unused;

      assign blk_unused = blk_gp ^ blk_gg;

      // Signed overflow: carry into the MSB disagrees with carry out of it.
      always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (take) begin
          ovf_d  = blk_ctop ^ blk_cout;
          zero_d = (new_sum == '0);
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = stg[NBLK-1].vld_q;
  assign out_sum   = stg[NBLK-1].sum_q;
  assign out_cout  = stg[NBLK-1].cy_q;
  assign out_tag   = stg[NBLK-1].tag_q;
  assign out_ovf   = stg[NBLK-1].fin.ovf_q;
  assign out_zero  = stg[NBLK-1].fin.zero_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder at WIDTH=32, BLOCK=8 (latency 4).
module tb_pipe_cla_adder;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  always #5 clock = ~clock;

  pipe_cla_adder #(.WIDTH(W), .BLOCK(8), .TAG_W(TW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic op,
                                 logic [TW-1:0] tag);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         c;
    res_t         r;
    bb     = op ? ~b : b;
    c      = op ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    r.zero = (r.sum == '0);
    r.tag  = tag;
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drives one cycle of inputs at the falling edge and snapshots the outputs
  // that the next rising edge will see; records the expectation on acceptance.
  task automatic drive(input logic rst, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic op,
                       input logic [TW-1:0] tag, input logic ordy,
                       output logic fire, output logic rdy, output res_t got);
    @(negedge clock);
    reset     = rst;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_op     = op;
    in_tag    = tag;
    out_ready = ordy;
    #1;
    fire = out_valid && out_ready && !rst;
    rdy  = in_ready;
    got  = {out_sum, out_cout, out_ovf, out_zero, out_tag};
    if (!rst && in_valid && in_ready) exp_q.push_back(model(a, b, cin, op, tag));
  endtask

  task automatic test_reset();
    logic fire, rdy;
    res_t got;
    int   fires;
    drive(1'b1, 1'b1, 32'h1234_5678, 32'h1, 1'b0, 1'b0, 4'hA, 1'b1, fire, rdy, got);
    drive(1'b1, 1'b1, 32'h0000_00FF, 32'h1, 1'b1, 1'b0, 4'hB, 1'b1, fire, rdy, got);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, fire, rdy, got);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", got);
    end
    total++;
    if (rdy !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", rdy);
    end
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, fire, rdy, got);
      if (fire) fires++;
    end
    total++;
    if (fires != 0) begin
      bad++; $display("FAIL reset_no_accept got=%0d results want=0", fires);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]  ta[7] = '{32'h0000_00FF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h5,
                             32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0]  tb[7] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'h5, 32'h1, 32'h0, 32'h1};
    logic          tc[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic          to[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [TW-1:0] tt[7] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    res_t          want[7] = '{
      '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 4'd3},
      '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd5},
      '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 4'd6},
      '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'd7},
      '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd8},
      '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'd9},
      '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 4'd10}};
    logic fire, rdy, seen;
    res_t got, e;
    for (int n = 0; n < 7; n++) begin
      drive(1'b0, 1'b1, ta[n], tb[n], tc[n], to[n], tt[n], 1'b1, fire, rdy, got);
      seen = 1'b0;
      for (int lat = 1; lat <= 8 && !seen; lat++) begin
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, fire, rdy, got);
        if (fire) begin
          seen = 1'b1;
          total++;
          if (lat != 4) begin
            bad++; $display("FAIL directed%0d_latency got=%0d want=4", n, lat);
          end
          total++;
          if (got !== want[n]) begin
            bad++; $display("FAIL directed%0d_result got=%h want=%h", n, got, want[n]);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL directed%0d_scoreboard got=result want=empty", n);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              bad++; $display("FAIL directed%0d_model got=%h want=%h", n, got, e);
            end
          end
        end
      end
      if (!seen) begin
        total++; bad++;
        $display("FAIL directed%0d_timeout got=no result want=result", n);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a_t[6];
    logic [W-1:0] b_t[6];
    logic         op_t[6];
    logic         cin_t[6];
    logic         fire, rdy, v, ordy, want_rdy;
    res_t         got, held, e;
    int           sent, fires;
    for (int n = 0; n < 6; n++) begin
      a_t[n] = pick(); b_t[n] = pick(); op_t[n] = n[0]; cin_t[n] = $urandom % 2;
    end
    sent  = 0;
    fires = 0;
    held  = '0;
    for (int i = 1; i <= 20; i++) begin
      v    = (sent < 6);
      ordy = !(i >= 5 && i <= 8);
      drive(1'b0, v, a_t[sent % 6], b_t[sent % 6], cin_t[sent % 6], op_t[sent % 6],
            TW'(sent + 1), ordy, fire, rdy, got);
      want_rdy = !(i >= 5 && i <= 8);
      total++;
      if (rdy !== want_rdy) begin
        bad++; $display("FAIL b2b_in_ready cycle %0d got=%b want=%b", i, rdy, want_rdy);
      end
      if (v && rdy) sent++;
      if (i == 5) held = got;
      if (i >= 6 && i <= 8) begin
        total++;
        if (got !== held || out_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_stall_hold cycle %0d got=%h want=%h", i, got, held);
        end
      end
      if (fire) begin
        fires++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got=%h want=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++; $display("FAIL b2b_result got=%h want=%h", got, e);
          end
        end
      end
    end
    total++;
    if (fires != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count got=%0d results, %0d pending want=6, 0", fires, exp_q.size());
    end
  endtask

  task automatic test_reset_in_flight();
    logic fire, rdy, seen;
    res_t got, e;
    drive(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 4'h1, 1'b1, fire, rdy, got);
    drive(1'b0, 1'b1, 32'h3333_3333, 32'h1, 1'b0, 1'b1, 4'h2, 1'b1, fire, rdy, got);
    drive(1'b1, 1'b1, 32'h5555_5555, 32'h1, 1'b0, 1'b0, 4'h3, 1'b1, fire, rdy, got);
    exp_q.delete();
    drive(1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 4'hC, 1'b1, fire, rdy, got);
    total++;
    if (out_valid !== 1'b0 || rdy !== 1'b1) begin
      bad++; $display("FAIL flush_after_reset got valid=%b ready=%b want valid=0 ready=1", out_valid, rdy);
    end
    seen = 1'b0;
    for (int lat = 1; lat <= 10; lat++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, fire, rdy, got);
      if (fire) begin
        total++;
        if (seen || lat != 4) begin
          bad++; $display("FAIL flush_result_cycle got=%0d tag=%h want=4 tag=c", lat, got.tag);
        end
        seen = 1'b1;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL flush_extra got=%h want=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e || got.sum !== 32'h0001_0001) begin
            bad++; $display("FAIL flush_result got=%h want=%h", got, e);
          end
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL flush_timeout got=no result want=result");
    end
  endtask

  task automatic test_random();
    logic fire, rdy;
    res_t got, e;
    for (int i = 0; i < 90; i++) begin
      if (i < 70)
        drive(1'b0, ($urandom % 4) != 0, pick(), pick(), 1'($urandom % 2), 1'($urandom % 2),
              TW'($urandom), ($urandom % 3) != 0, fire, rdy, got);
      else
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, fire, rdy, got);
      if (fire) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra got=%h want=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++; $display("FAIL rand_result got=%h want=%h", got, e);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL rand_lost got=%0d pending want=0", exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_op     = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; a multiple of BLOCK.
REQ-002 SHALL have parameter BLOCK, default 8, carry-lookahead group width and bits resolved per pipeline stage.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-004 SHALL use one clock, clock; reset is synchronous and active-high, reset.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operation presented.
REQ-008 in_ready  output  1  operation accepted this cycle when in_valid and in_ready are both high.
REQ-009 in_a  input  WIDTH  operand A.
REQ-010 in_b  input  WIDTH  operand B.
REQ-011 in_cin  input  1  carry-in, add mode only.
REQ-012 in_op  input  1  0 = add (A+B+cin), 1 = subtract (A-B).
REQ-013 in_tag  input  TAG_W  sideband tag.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  consumer takes the result when out_valid and out_ready are both high.
REQ-016 out_sum  output  WIDTH  result.
REQ-017 out_cout  output  1  carry out of the MSB.
REQ-018 out_ovf  output  1  two's-complement signed overflow.
REQ-019 out_zero  output  1  high when out_sum == 0.
REQ-020 out_tag  output  TAG_W  tag of the operation being output.

Function
REQ-021 SHALL have NBLK = WIDTH/BLOCK pipeline stages; stage k resolves bits [k*BLOCK +: BLOCK] using group lookahead: per-bit P = a^b, per-bit G = a&b, group P/G, and carry-in from the registered carry of stage k-1.
REQ-022 SHALL make the result of an operation accepted in cycle t visible with out_valid high in cycle t+NBLK when there is no stall.
REQ-023 SHALL, in subtract mode, use B' = ~B and carry-in = 1 and ignore in_cin; in add mode, B' = B and carry-in = in_cin.
REQ-024 SHALL carry each operation's not-yet-processed operand bits, its partial sum, inter-stage carry, op and tag with it through the stages (skewed pipeline).
REQ-025 SHALL define out_cout = carry out of bit WIDTH-1 (for subtract, 1 means no borrow) and out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 SHALL stall every stage together when out_valid=1 and out_ready=0; no stage register changes while stalled.
REQ-027 SHALL drive in_ready = !(out_valid && !out_ready), with no other dependency.
REQ-028 SHALL accept a new operation and retire the output in the same cycle when out_ready=1, sustaining one operation per cycle.
REQ-029 SHALL let empty (bubble) stages advance; a bubble SHALL never raise out_valid.
REQ-030 SHALL preserve order; no operation is lost or duplicated under any stall pattern.
REQ-031 SHALL hold out_sum, out_cout, out_ovf, out_zero and out_tag stable while out_valid=1 and out_ready=0.
REQ-032 SHALL support the degenerate case NBLK=1 (WIDTH == BLOCK) with latency 1.

Reset
REQ-033 On reset SHALL clear all stage valid bits, out_valid, out_sum, out_cout, out_ovf, out_zero and out_tag to 0 in the following cycle.
REQ-034 SHALL discard in-flight operations on reset; an in_valid presented during reset is not accepted.
REQ-035 SHALL drive in_ready=1 in the cycle after reset deasserts.

Structure
REQ-036 SHALL keep the default WIDTH, BLOCK and TAG_W constants in the shared processor package.
REQ-037 SHALL instantiate sub-module cla_block (parametrised BLOCK-bit lookahead group producing sum, group P, group G and carry-out) once per stage via generate.

Verification (WIDTH=32, BLOCK=8, latency 4)
REQ-038 Add 0x000000FF + 0x00000001, cin=0, tag 3 -> 4 cycles later sum 0x00000100, cout 0, ovf 0, zero 0, tag 3 (carry crosses the stage boundary).
REQ-039 Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, ovf 1, cout 0; add 0xFFFFFFFF + 0xFFFFFFFF -> sum 0xFFFFFFFE, cout 1, ovf 0.
REQ-040 Subtract 5 - 5 with cin=1 -> sum 0, zero 1, cout 1; subtract 0 - 1 -> sum 0xFFFFFFFF, cout 0.
REQ-041 Send 6 back-to-back operations with out_ready held low for cycles 5-8 -> in_ready low for exactly those stalled cycles, all 6 results in order, no duplicates.
REQ-042 Reset for 1 cycle with 2 operations in flight -> out_valid 0 in the next cycle, neither result ever appears, next accepted operation emerges after 4 cycles.
